// File: rtl/gfp8_pkg.sv
// Shared GFP8 constants, sequencer state type and the per-group result record.
package gfp8_pkg;

  localparam int unsigned GFP_GROUP_SIZE = 32;
  localparam int unsigned GFP_INT_SIZE   = 8;
  localparam int unsigned GFP_BIAS       = 15;
  localparam int unsigned GFP_EXP_W      = 8;
  localparam int unsigned GFP_SRC_EXP_W  = 5;
  // 32 products of int8 x int8 peak at +2^19, so 21 signed bits hold any group sum
  localparam int unsigned GFP_DOT_W      = 21;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic signed [GFP_DOT_W-1:0] mantissa;
    logic signed [GFP_EXP_W-1:0] exponent;
    logic                        valid;
    logic                        skip;
  } group_result_t;

endpackage

// File: rtl/gfp8_align_add.sv
// Block accumulator: aligns each incoming group result to the larger exponent and adds.
module gfp8_align_add
  import gfp8_pkg::*;
#(
  parameter int unsigned ACC_W = 40
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_clear,
  input  logic                        i_valid,
  input  logic signed [GFP_DOT_W-1:0] i_mantissa,
  input  logic signed [GFP_EXP_W-1:0] i_exponent,
  output logic signed [ACC_W-1:0]     o_acc,
  output logic signed [GFP_EXP_W-1:0] o_exponent,
  output logic                        o_empty
);

  localparam int unsigned SH_MAX = ACC_W - 1;

  logic signed [ACC_W-1:0] m_ext;
  logic signed [ACC_W-1:0] acc_sh;
  logic signed [ACC_W-1:0] m_sh;
  logic        [GFP_EXP_W:0] diff;
  logic        [GFP_EXP_W:0] shamt;
  logic                      incoming_larger;

  always_comb begin
    m_ext           = ACC_W'(i_mantissa);
    incoming_larger = i_exponent > o_exponent;
    diff            = incoming_larger
                    ? {i_exponent[GFP_EXP_W-1], i_exponent} - {o_exponent[GFP_EXP_W-1], o_exponent}
                    : {o_exponent[GFP_EXP_W-1], o_exponent} - {i_exponent[GFP_EXP_W-1], i_exponent};
    // clamping at ACC_W-1 still yields a pure sign fill for any larger distance
    shamt  = (diff > (GFP_EXP_W+1)'(SH_MAX)) ? (GFP_EXP_W+1)'(SH_MAX) : diff;
    acc_sh = o_acc >>> shamt;
    m_sh   = m_ext >>> shamt;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      o_acc      <= '0;
      o_exponent <= '0;
      o_empty    <= 1'b1;
    end else if (i_valid) begin
      o_empty <= 1'b0;
      if (o_empty) begin
        o_acc      <= m_ext;
        o_exponent <= i_exponent;
      end else if (incoming_larger) begin
        o_acc      <= acc_sh + m_ext;
        o_exponent <= i_exponent;
      end else begin
        o_acc <= o_acc + m_sh;
      end
    end
  end

endmodule

// File: rtl/gfp8_group_dot.sv
// Dot product of one GFP8 group pair; result mantissa and unbiased exponent registered.
module gfp8_group_dot
  import gfp8_pkg::*;
(
  input  logic                                     i_clk,
  input  logic [GFP_SRC_EXP_W-1:0]                 i_exp_left,
  input  logic [GFP_GROUP_SIZE*GFP_INT_SIZE-1:0]   i_man_left,
  input  logic [GFP_SRC_EXP_W-1:0]                 i_exp_right,
  input  logic [GFP_GROUP_SIZE*GFP_INT_SIZE-1:0]   i_man_right,
  output logic signed [GFP_DOT_W-1:0]              o_mantissa,
  output logic signed [GFP_EXP_W-1:0]              o_exponent
);

  logic signed [GFP_DOT_W-1:0] sum;
  logic        [GFP_EXP_W-1:0] exp_sum;

  always_comb begin
    sum = '0;
    for (int unsigned i = 0; i < GFP_GROUP_SIZE; i++) begin
      sum = sum + GFP_DOT_W'($signed(i_man_left[i*GFP_INT_SIZE +: GFP_INT_SIZE]) *
                             $signed(i_man_right[i*GFP_INT_SIZE +: GFP_INT_SIZE]));
    end
    exp_sum = GFP_EXP_W'(i_exp_left) + GFP_EXP_W'(i_exp_right) - GFP_EXP_W'(2 * GFP_BIAS);
  end

  always_ff @(posedge i_clk) begin
    o_mantissa <= sum;
    o_exponent <= $signed(exp_sum);
  end

endmodule

// File: rtl/gfp8_block_dot_seq.sv
// Walks a block of GFP8 group pairs through one group-dot unit and returns the block dot product.
module gfp8_block_dot_seq
  import gfp8_pkg::*;
#(
  parameter int unsigned MAX_GROUPS = 128,
  parameter int unsigned ADDR_W     = 7,
  parameter int unsigned ACC_W      = 40
) (
  input  logic                              i_clk,
  input  logic                              i_reset,
  input  logic                              i_cmd_valid,
  output logic                              o_cmd_ready,
  input  logic [$clog2(MAX_GROUPS):0]       i_cmd_num_groups,
  input  logic [ADDR_W-1:0]                 i_cmd_left_base,
  input  logic [ADDR_W-1:0]                 i_cmd_right_base,
  output logic                              o_rd_en,
  output logic [ADDR_W-1:0]                 o_rd_addr_left,
  output logic [ADDR_W-1:0]                 o_rd_addr_right,
  input  logic [4:0]                        i_rd_exp_left,
  input  logic [255:0]                      i_rd_man_left,
  input  logic [4:0]                        i_rd_exp_right,
  input  logic [255:0]                      i_rd_man_right,
  output logic                              o_result_valid,
  input  logic                              i_result_ready,
  output logic [ACC_W-1:0]                  o_result_mantissa,
  output logic [7:0]                        o_result_exponent,
  output logic                              o_busy
);

  localparam int unsigned CNT_W = $clog2(MAX_GROUPS) + 1;

  state_t                      state;
  logic [CNT_W-1:0]            remaining;
  logic                        s1_valid;
  logic                        s2_valid;
  logic                        s2_src_skip;
  logic                        cmd_fire;
  logic signed [GFP_DOT_W-1:0] dot_mantissa;
  logic signed [GFP_EXP_W-1:0] dot_exponent;
  logic signed [ACC_W-1:0]     acc;
  logic signed [GFP_EXP_W-1:0] acc_exponent;
  logic                        acc_empty;
  group_result_t               grp;

  assign cmd_fire = i_cmd_valid && o_cmd_ready;

  gfp8_group_dot u_group_dot (
    .i_clk       (i_clk),
    .i_exp_left  (i_rd_exp_left),
    .i_man_left  (i_rd_man_left),
    .i_exp_right (i_rd_exp_right),
    .i_man_right (i_rd_man_right),
    .o_mantissa  (dot_mantissa),
    .o_exponent  (dot_exponent)
  );

  // stage 1 = read data on the bus, stage 2 = registered dot result
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s1_valid    <= 1'b0;
      s2_valid    <= 1'b0;
      s2_src_skip <= 1'b0;
    end else begin
      s1_valid    <= o_rd_en;
      s2_valid    <= s1_valid;
      s2_src_skip <= (i_rd_exp_left == '0) || (i_rd_exp_right == '0);
    end
  end

  always_comb begin
    grp.mantissa = dot_mantissa;
    grp.exponent = dot_exponent;
    grp.valid    = s2_valid;
    grp.skip     = s2_src_skip || (dot_mantissa == '0);
  end

  gfp8_align_add #(.ACC_W(ACC_W)) u_align_add (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_clear    (cmd_fire),
    .i_valid    (grp.valid && !grp.skip),
    .i_mantissa (grp.mantissa),
    .i_exponent (grp.exponent),
    .o_acc      (acc),
    .o_exponent (acc_exponent),
    .o_empty    (acc_empty)
  );

  // an all-skipped block leaves the accumulator at its cleared 0/0
  assign o_result_mantissa = acc;
  assign o_result_exponent = acc_exponent;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state           <= ST_IDLE;
      o_cmd_ready     <= 1'b1;
      o_busy          <= 1'b0;
      o_rd_en         <= 1'b0;
      o_result_valid  <= 1'b0;
      remaining       <= '0;
      o_rd_addr_left  <= '0;
      o_rd_addr_right <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_fire) begin
            o_cmd_ready     <= 1'b0;
            o_busy          <= 1'b1;
            o_rd_addr_left  <= i_cmd_left_base;
            o_rd_addr_right <= i_cmd_right_base;
            if (i_cmd_num_groups == '0) begin
              state          <= ST_DONE;
              o_result_valid <= 1'b1;
            end else begin
              state     <= ST_RUN;
              o_rd_en   <= 1'b1;
              remaining <= i_cmd_num_groups - CNT_W'(1);
            end
          end
        end
        ST_RUN: begin
          if (remaining == '0) begin
            o_rd_en <= 1'b0;
            state   <= ST_DRAIN;
          end else begin
            remaining       <= remaining - CNT_W'(1);
            o_rd_addr_left  <= o_rd_addr_left + ADDR_W'(1);
            o_rd_addr_right <= o_rd_addr_right + ADDR_W'(1);
          end
        end
        ST_DRAIN: begin
          if (s2_valid && !s1_valid) begin
            state          <= ST_DONE;
            o_result_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (i_result_ready) begin
            state          <= ST_IDLE;
            o_result_valid <= 1'b0;
            o_cmd_ready    <= 1'b1;
            o_busy         <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gfp8_block_dot_seq.sv
// Bench for gfp8_block_dot_seq: buffer model, block-dot reference model and cycle-level checks.
module tb_gfp8_block_dot_seq;

  localparam int NG = 128;

  logic         clk = 1'b0;
  logic         reset;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [7:0]   cmd_num;
  logic [6:0]   cmd_lbase;
  logic [6:0]   cmd_rbase;
  logic         rd_en;
  logic [6:0]   rd_addr_left;
  logic [6:0]   rd_addr_right;
  logic [4:0]   rd_exp_left  = '0;
  logic [255:0] rd_man_left  = '0;
  logic [4:0]   rd_exp_right = '0;
  logic [255:0] rd_man_right = '0;
  logic         result_valid;
  logic         result_ready;
  logic [39:0]  result_mantissa;
  logic [7:0]   result_exponent;
  logic         busy;

  logic [4:0]   mem_el [0:NG-1];
  logic [4:0]   mem_er [0:NG-1];
  logic [255:0] mem_ml [0:NG-1];
  logic [255:0] mem_mr [0:NG-1];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gfp8_block_dot_seq #(.MAX_GROUPS(128), .ADDR_W(7), .ACC_W(40)) dut (
    .i_clk             (clk),
    .i_reset           (reset),
    .i_cmd_valid       (cmd_valid),
    .o_cmd_ready       (cmd_ready),
    .i_cmd_num_groups  (cmd_num),
    .i_cmd_left_base   (cmd_lbase),
    .i_cmd_right_base  (cmd_rbase),
    .o_rd_en           (rd_en),
    .o_rd_addr_left    (rd_addr_left),
    .o_rd_addr_right   (rd_addr_right),
    .i_rd_exp_left     (rd_exp_left),
    .i_rd_man_left     (rd_man_left),
    .i_rd_exp_right    (rd_exp_right),
    .i_rd_man_right    (rd_man_right),
    .o_result_valid    (result_valid),
    .i_result_ready    (result_ready),
    .o_result_mantissa (result_mantissa),
    .o_result_exponent (result_exponent),
    .o_busy            (busy)
  );

  // operand buffers: one-cycle read latency
  always @(posedge clk) begin
    if (rd_en) begin
      rd_exp_left  <= mem_el[rd_addr_left];
      rd_man_left  <= mem_ml[rd_addr_left];
      rd_exp_right <= mem_er[rd_addr_right];
      rd_man_right <= mem_mr[rd_addr_right];
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_group(input int a, input int el, input int er, input int ml, input int mr);
    mem_el[a] = 5'(el);
    mem_er[a] = 5'(er);
    for (int i = 0; i < 32; i++) begin
      mem_ml[a][i*8 +: 8] = 8'(ml);
      mem_mr[a][i*8 +: 8] = 8'(mr);
    end
  endtask

  task automatic rand_group(input int a);
    mem_el[a] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    mem_er[a] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    for (int w = 0; w < 8; w++) begin
      mem_ml[a][w*32 +: 32] = $urandom;
      mem_mr[a][w*32 +: 32] = $urandom;
    end
  endtask

  // Block dot product from the buffer contents: per-group dot, skip rule, align-to-larger-exponent sum.
  function automatic void model(input int n, input int lb, input int rb,
                                output longint m, output longint e);
    longint acc = 0;
    longint acc_e = 0;
    bit     empty = 1'b1;
    for (int k = 0; k < n; k++) begin
      int     la = (lb + k) % NG;
      int     ra = (rb + k) % NG;
      longint dm = 0;
      longint de;
      for (int i = 0; i < 32; i++) begin
        byte a;
        byte b;
        a = mem_ml[la][i*8 +: 8];
        b = mem_mr[ra][i*8 +: 8];
        dm += longint'(int'(a) * int'(b));
      end
      de = longint'(mem_el[la]) + longint'(mem_er[ra]) - 30;
      if (mem_el[la] == 0 || mem_er[ra] == 0 || dm == 0) continue;
      if (empty) begin
        acc = dm; acc_e = de; empty = 1'b0;
      end else if (de > acc_e) begin
        acc = (acc >>> ((de - acc_e) > 63 ? 63 : (de - acc_e))) + dm;
        acc_e = de;
      end else begin
        acc = acc + (dm >>> ((acc_e - de) > 63 ? 63 : (acc_e - de)));
      end
    end
    m = acc;
    e = acc_e;
  endfunction

  task automatic run_cmd(input int n, input int lb, input int rb, input int hold);
    longint em, ee, hm, he;
    int     v;
    model(n, lb, rb, em, ee);
    v = (n == 0) ? 1 : n + 3;
    @(negedge clk);
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_num   = 8'(n);
    cmd_lbase = 7'(lb);
    cmd_rbase = 7'(rb);
    @(negedge clk);
    for (int c = 1; c < v; c++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      check("rd_en", rd_en, longint'(c <= n));
      if (c <= n) begin
        check("rd_addr_left", rd_addr_left, (lb + c - 1) % NG);
        check("rd_addr_right", rd_addr_right, (rb + c - 1) % NG);
      end
      check("valid_early", result_valid, 0);
      check("cmd_ready_busy", cmd_ready, 0);
      check("busy", busy, 1);
      @(negedge clk);
    end
    check("result_valid", result_valid, 1);
    check("result_mantissa", $signed(result_mantissa), em);
    check("result_exponent", $signed(result_exponent), ee);
    check("rd_en_done", rd_en, 0);
    check("cmd_ready_done", cmd_ready, 0);
    hm = $signed(result_mantissa);
    he = $signed(result_exponent);
    for (int h = 0; h < hold; h++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("hold_valid", result_valid, 1);
      check("hold_mantissa", $signed(result_mantissa), hm);
      check("hold_exponent", $signed(result_exponent), he);
      check("hold_cmd_ready", cmd_ready, 0);
    end
    cmd_valid    = 1'b0;
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    check("valid_after_hs", result_valid, 0);
    check("cmd_ready_after_hs", cmd_ready, 1);
    check("busy_after_hs", busy, 0);
  endtask

  initial begin
    longint pm, pe;
    reset        = 1'b1;
    cmd_valid    = 1'b0;
    cmd_num      = '0;
    cmd_lbase    = '0;
    cmd_rbase    = '0;
    result_ready = 1'b0;
    for (int g = 0; g < NG; g++) set_group(g, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rd_en", rd_en, 0);
    check("rst_valid", result_valid, 0);
    check("rst_mantissa", result_mantissa, 0);
    check("rst_exponent", result_exponent, 0);
    check("rst_busy", busy, 0);

    // single group: 32 x (1*1) at exponent 15+15-30
    set_group(0, 15, 15, 1, 1);
    model(1, 0, 0, pm, pe);
    check("model_single_m", pm, 32);
    check("model_single_e", pe, 0);
    run_cmd(1, 0, 0, 0);

    // alignment, larger exponent first then second
    set_group(10, 16, 15, 2, 1);
    set_group(11, 15, 15, 1, 1);
    model(2, 10, 10, pm, pe);
    check("model_align_a_m", pm, 80);
    check("model_align_a_e", pe, 1);
    run_cmd(2, 10, 10, 1);
    set_group(20, 15, 15, 1, 1);
    set_group(21, 16, 15, 2, 1);
    model(2, 20, 20, pm, pe);
    check("model_align_b_m", pm, 80);
    check("model_align_b_e", pe, 1);
    run_cmd(2, 20, 20, 0);

    // zero source exponent skips its group
    set_group(30, 0, 15, 3, 5);
    set_group(31, 15, 15, 1, 1);
    model(2, 30, 30, pm, pe);
    check("model_skip_m", pm, 32);
    check("model_skip_e", pe, 0);
    run_cmd(2, 30, 30, 0);

    // zero dot mantissa skips its group
    set_group(50, 15, 15, 0, 7);
    set_group(51, 15, 15, 1, 1);
    run_cmd(2, 50, 50, 0);

    // large shift: -32 shifted by 32 becomes -1
    set_group(40, 31, 31, 1, 1);
    set_group(41, 15, 15, -1, 1);
    model(2, 40, 40, pm, pe);
    check("model_signfill_m", pm, 31);
    check("model_signfill_e", pe, 32);
    run_cmd(2, 40, 40, 0);

    // empty block, held result
    model(0, 3, 3, pm, pe);
    check("model_zero_m", pm, 0);
    check("model_zero_e", pe, 0);
    run_cmd(0, 3, 3, 5);

    // address wrap with distinct left/right bases
    for (int g = 124; g < NG; g++) rand_group(g);
    for (int g = 0; g < 4; g++) rand_group(g);
    run_cmd(4, 126, 125, 0);

    // reset in the middle of a run abandons the command
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_num   = 8'd8;
    cmd_lbase = 7'd60;
    cmd_rbase = 7'd60;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_rd_en", rd_en, 0);
    check("midrst_valid", result_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_cmd_ready", cmd_ready, 1);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check("midrst_no_result", result_valid, 0);
    end
    set_group(0, 15, 15, 1, 1);
    run_cmd(1, 0, 0, 0);

    // randomized blocks
    for (int t = 0; t < 14; t++) begin
      int n;
      for (int g = 0; g < NG; g++) rand_group(g);
      n = (t % 3 == 0) ? $urandom_range(1, 128) : $urandom_range(1, 12);
      run_cmd(n, $urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 3));
    end
    run_cmd(128, 0, 64, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
